// File: rtl/vga_timing_monitor.sv
// VGA sync timing monitor: measures line/frame geometry and tracks lock against expected timing.
// Optional pixel probe is compiled in when VGA_PIXEL_PROBE_EN is defined.

module vga_timing_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clock25MHz,
    input  logic        resetN,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    input  logic [9:0]  probeH,
    input  logic [9:0]  probeV,
    output logic [10:0] lineLength,
    output logic [7:0]  hsyncWidth,
    output logic [9:0]  frameLines,
    output logic [3:0]  vsyncWidth,
    output logic        locked,
    output logic        measValid,
    output logic [7:0]  errorCount,
    output logic [11:0] probeRGB,
    output logic        probeValid
);

    localparam logic [10:0] LP_H_TOTAL = H_TOTAL[10:0];
    localparam logic [7:0]  LP_H_SYNC  = H_SYNC[7:0];
    localparam logic [9:0]  LP_V_TOTAL = V_TOTAL[9:0];
    localparam logic [3:0]  LP_V_SYNC  = V_SYNC[3:0];
    localparam logic [2:0]  LP_LOCK    = LOCK_FRAMES[2:0];

    // state  | meaning
    // SEARCH | no frame reference yet (after reset or sync loss)
    // CHECK  | counting consecutive good frames
    // LOCKED | incoming timing matches the expected geometry
    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_CHECK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    logic [13:0] r_in_d1;
    logic [13:0] r_in_d2;
    logic        r_hs_d3;
    logic        r_vs_d3;
    logic [1:0]  r_warm;

    logic        w_hs;
    logic        w_vs;
    logic [11:0] w_rgb;
    logic        w_warm;
    logic        w_hfall;
    logic        w_hrise;
    logic        w_vfall;
    logic        w_vrise;

    assign w_hs  = r_in_d2[13];
    assign w_vs  = r_in_d2[12];
    assign w_rgb = r_in_d2[11:0];

    // Edges are only trusted once the whole delay chain holds post-reset samples.
    assign w_warm  = (r_warm == 2'd3);
    assign w_hfall = w_warm &  r_hs_d3 & ~w_hs;
    assign w_hrise = w_warm & ~r_hs_d3 &  w_hs;
    assign w_vfall = w_warm &  r_vs_d3 & ~w_vs;
    assign w_vrise = w_warm & ~r_vs_d3 &  w_vs;

    always_ff @(posedge clock25MHz or negedge resetN) begin
        if (!resetN) begin
            r_in_d1 <= '0;
            r_in_d2 <= '0;
            r_hs_d3 <= 1'b0;
            r_vs_d3 <= 1'b0;
            r_warm  <= 2'd0;
        end else begin
            r_in_d1 <= {hsync, vsync, red, green, blue};
            r_in_d2 <= r_in_d1;
            r_hs_d3 <= w_hs;
            r_vs_d3 <= w_vs;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
        end
    end

    logic [10:0] r_hcnt;
    logic [10:0] r_line_length;
    logic [7:0]  r_hlow_cnt;
    logic [7:0]  r_hsync_width;
    logic [9:0]  r_line_cnt;
    logic [9:0]  r_frame_lines;
    logic [3:0]  r_vlow_cnt;
    logic [3:0]  r_vsync_width;
    logic        r_frame_bad;
    logic [10:0] r_idle_cnt;

    logic [10:0] w_hcnt_inc;
    logic [7:0]  w_hlow_inc;
    logic [9:0]  w_line_inc;
    logic [9:0]  w_line_next;
    logic [3:0]  w_vlow_inc;
    logic        w_bad_evt;
    logic        w_frame_good;
    logic        w_timeout;

    assign w_hcnt_inc  = (r_hcnt == 11'h7FF) ? r_hcnt : r_hcnt + 11'd1;
    assign w_hlow_inc  = (r_hlow_cnt == 8'hFF) ? r_hlow_cnt : r_hlow_cnt + 8'd1;
    assign w_line_inc  = (r_line_cnt == 10'h3FF) ? r_line_cnt : r_line_cnt + 10'd1;
    assign w_line_next = w_hfall ? w_line_inc : r_line_cnt;
    assign w_vlow_inc  = (r_vlow_cnt == 4'hF) ? r_vlow_cnt : r_vlow_cnt + 4'd1;

    assign w_bad_evt = (w_hfall && (w_hcnt_inc != LP_H_TOTAL))
                     | (w_hrise && (r_hlow_cnt != LP_H_SYNC));

    // Events coincident with vFall still belong to the frame being closed.
    assign w_frame_good = !(r_frame_bad || w_bad_evt)
                        && (w_line_next == LP_V_TOTAL)
                        && (r_vsync_width == LP_V_SYNC);

    assign w_timeout = (r_idle_cnt == 11'd0) && !w_hfall;

    always_ff @(posedge clock25MHz or negedge resetN) begin
        if (!resetN) begin
            r_hcnt        <= '0;
            r_line_length <= '0;
            r_hlow_cnt    <= '0;
            r_hsync_width <= '0;
        end else begin
            if (w_hfall) begin
                r_hcnt        <= 11'd0;
                r_line_length <= w_hcnt_inc;
            end else begin
                r_hcnt <= w_hcnt_inc;
            end
            if (!w_hs) begin
                r_hlow_cnt <= w_hfall ? 8'd1 : w_hlow_inc;
            end
            if (w_hrise) begin
                r_hsync_width <= r_hlow_cnt;
            end
        end
    end

    always_ff @(posedge clock25MHz or negedge resetN) begin
        if (!resetN) begin
            r_line_cnt    <= '0;
            r_frame_lines <= '0;
            r_vlow_cnt    <= '0;
            r_vsync_width <= '0;
            r_frame_bad   <= 1'b0;
        end else begin
            if (w_vfall) begin
                r_frame_lines <= w_line_next;
                r_line_cnt    <= 10'd0;
                r_frame_bad   <= 1'b0;
            end else begin
                r_line_cnt <= w_line_next;
                if (w_bad_evt) begin
                    r_frame_bad <= 1'b1;
                end
            end
            if (!w_vs) begin
                if (w_vfall) begin
                    r_vlow_cnt <= w_hfall ? 4'd1 : 4'd0;
                end else if (w_hfall) begin
                    r_vlow_cnt <= w_vlow_inc;
                end
            end
            if (w_vrise) begin
                r_vsync_width <= r_vlow_cnt;
            end
        end
    end

    // Down-counter reloaded on every line start; terminal count means sync is gone.
    always_ff @(posedge clock25MHz or negedge resetN) begin
        if (!resetN) begin
            r_idle_cnt <= '0;
        end else if (w_hfall) begin
            r_idle_cnt <= 11'h7FF;
        end else if (r_idle_cnt != 11'd0) begin
            r_idle_cnt <= r_idle_cnt - 11'd1;
        end
    end

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_good_cnt;
    logic [2:0]  w_good_next;
    logic        w_err_inc;
    logic        w_meas;
    logic        r_meas_valid;
    logic [7:0]  r_err_cnt;

    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good_cnt;
        w_err_inc    = 1'b0;
        w_meas       = 1'b0;
        if (w_timeout) begin
            w_state_next = S_SEARCH;
            w_good_next  = 3'd0;
            w_err_inc    = (r_state == S_LOCKED);
        end else if (w_vfall) begin
            case (r_state)
                S_SEARCH: begin
                    w_state_next = S_CHECK;
                    w_good_next  = 3'd0;
                end
                S_CHECK: begin
                    w_meas = 1'b1;
                    if (w_frame_good) begin
                        w_good_next = r_good_cnt + 3'd1;
                        if (r_good_cnt + 3'd1 == LP_LOCK) begin
                            w_state_next = S_LOCKED;
                        end
                    end else begin
                        w_good_next = 3'd0;
                    end
                end
                S_LOCKED: begin
                    w_meas = 1'b1;
                    if (!w_frame_good) begin
                        w_state_next = S_CHECK;
                        w_good_next  = 3'd0;
                        w_err_inc    = 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_SEARCH;
                    w_good_next  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock25MHz or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_SEARCH;
            r_good_cnt   <= '0;
            r_meas_valid <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_good_cnt   <= w_good_next;
            r_meas_valid <= w_meas;
            if (w_err_inc && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

`ifdef VGA_PIXEL_PROBE_EN
    logic [11:0] r_probe_rgb;
    logic        r_probe_valid;

    always_ff @(posedge clock25MHz or negedge resetN) begin
        if (!resetN) begin
            r_probe_rgb   <= '0;
            r_probe_valid <= 1'b0;
        end else if ((r_hcnt == {1'b0, probeH}) && (r_line_cnt == probeV)) begin
            r_probe_rgb   <= w_rgb;
            r_probe_valid <= 1'b1;
        end else begin
            r_probe_valid <= 1'b0;
        end
    end

    assign probeRGB   = r_probe_rgb;
    assign probeValid = r_probe_valid;
`else
    logic w_probe_unused;
    assign w_probe_unused = ^{probeH, probeV, w_rgb};
    assign probeRGB       = 12'd0;
    assign probeValid     = 1'b0;
`endif

    assign lineLength = r_line_length;
    assign hsyncWidth = r_hsync_width;
    assign frameLines = r_frame_lines;
    assign vsyncWidth = r_vsync_width;
    assign locked     = (r_state == S_LOCKED);
    assign measValid  = r_meas_valid;
    assign errorCount = r_err_cnt;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Testbench for vga_timing_monitor using a scaled-down video geometry and a frame-level lock model.

module tb_vga_timing_monitor;

    localparam int H_T   = 40;
    localparam int H_S   = 6;
    localparam int V_T   = 12;
    localparam int V_S   = 2;
    localparam int LOCK  = 2;
    localparam int PRB_H = 20;
    localparam int PRB_V = 4;

`ifdef VGA_PIXEL_PROBE_EN
    localparam logic [11:0] EXP_PROBE = 12'hF0A;
    localparam int          EXP_PPF   = 1;
`else
    localparam logic [11:0] EXP_PROBE = 12'h000;
    localparam int          EXP_PPF   = 0;
`endif

    logic        clock25MHz = 1'b0;
    logic        resetN;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic [9:0]  probeH;
    logic [9:0]  probeV;
    logic [10:0] lineLength;
    logic [7:0]  hsyncWidth;
    logic [9:0]  frameLines;
    logic [3:0]  vsyncWidth;
    logic        locked;
    logic        measValid;
    logic [7:0]  errorCount;
    logic [11:0] probeRGB;
    logic        probeValid;

    vga_timing_monitor #(
        .H_TOTAL(H_T), .H_SYNC(H_S), .V_TOTAL(V_T), .V_SYNC(V_S), .LOCK_FRAMES(LOCK)
    ) dut (
        .clock25MHz(clock25MHz), .resetN(resetN), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue), .probeH(probeH), .probeV(probeV),
        .lineLength(lineLength), .hsyncWidth(hsyncWidth), .frameLines(frameLines),
        .vsyncWidth(vsyncWidth), .locked(locked), .measValid(measValid),
        .errorCount(errorCount), .probeRGB(probeRGB), .probeValid(probeValid)
    );

    always #20 clock25MHz = ~clock25MHz;

    int tests = 0;
    int fails = 0;
    int meas_seen = 0;
    int probe_seen = 0;

    always @(negedge clock25MHz) begin
        if (measValid) meas_seen++;
        if (probeValid) probe_seen++;
    end

    // Frame-level reference: lock holds while the run of consecutive good frames reaches LOCK.
    int exp_err, exp_meas, streak, meas_base;
    bit armed;
    int p_n, p_v, p_lastlen, p_lasthsw;
    bit p_good;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pix(input logic h, input logic v, input logic [11:0] rgb);
        hsync = h;
        vsync = v;
        {red, green, blue} = rgb;
        @(posedge clock25MHz);
        #1;
    endtask

    task automatic boundary();
        if (armed) begin
            exp_meas++;
            if (p_good) begin
                streak++;
            end else begin
                if (streak >= LOCK && exp_err < 255) exp_err++;
                streak = 0;
            end
            check("frameLines", 32'(frameLines), 32'(p_n));
            check("vsyncWidth", 32'(vsyncWidth), 32'(p_v));
            check("lineLength", 32'(lineLength), 32'(p_lastlen));
            check("hsyncWidth", 32'(hsyncWidth), 32'(p_lasthsw));
            check("probeRGB", 32'(probeRGB), 32'(EXP_PROBE));
        end else begin
            armed  = 1'b1;
            streak = 0;
        end
        check("locked", 32'(locked), 32'(streak >= LOCK));
        check("errorCount", 32'(errorCount), 32'(exp_err));
        check("measCount", 32'(meas_seen - meas_base), 32'(exp_meas));
    endtask

    task automatic send_frame(input int n, input int v, input int bad_line, input int bad_hsw,
                              input int long_line, input int long_len);
        for (int l = 0; l < n; l++) begin
            int len;
            int hw;
            len = (l == long_line) ? long_len : H_T;
            hw  = (l == bad_line) ? bad_hsw : H_S;
            for (int p = 0; p < len; p++) begin
                logic [11:0] rgb;
                rgb = (l == PRB_V && (p == PRB_H || p == PRB_H + 1)) ? 12'hF0A : 12'($urandom);
                pix(logic'(p >= hw), logic'(l >= v), rgb);
                if (l == 0 && p == 5) boundary();
            end
        end
        p_n       = n;
        p_v       = v;
        p_lastlen = (long_line == n - 1) ? long_len : H_T;
        p_lasthsw = (bad_line == n - 1) ? bad_hsw : H_S;
        p_good    = (n == V_T) && (v == V_S) && (long_line < 0) && (bad_line < 0);
    endtask

    task automatic good_frame();
        send_frame(V_T, V_S, -1, 0, -1, 0);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        #1;
        check("rst_lineLength", 32'(lineLength), 32'd0);
        check("rst_hsyncWidth", 32'(hsyncWidth), 32'd0);
        check("rst_frameLines", 32'(frameLines), 32'd0);
        check("rst_vsyncWidth", 32'(vsyncWidth), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_measValid", 32'(measValid), 32'd0);
        check("rst_errorCount", 32'(errorCount), 32'd0);
        check("rst_probeRGB", 32'(probeRGB), 32'd0);
        check("rst_probeValid", 32'(probeValid), 32'd0);
        repeat (3) pix(1'b1, 1'b1, 12'h000);
        resetN    = 1'b1;
        armed     = 1'b0;
        streak    = 0;
        exp_err   = 0;
        exp_meas  = 0;
        meas_base = meas_seen;
        repeat (20) pix(1'b1, 1'b1, 12'h000);
    endtask

    task automatic idle_timeout();
        for (int k = 0; k < 3000; k++) begin
            pix(1'b1, 1'b1, 12'h000);
            if (k == 1900) check("still_locked_pre_timeout", 32'(locked), 32'(streak >= LOCK));
            if (k == 2100) begin
                if (streak >= LOCK && exp_err < 255) exp_err++;
                streak = 0;
                armed  = 1'b0;
                check("timeout_locked", 32'(locked), 32'd0);
                check("timeout_errorCount", 32'(errorCount), 32'(exp_err));
            end
        end
    endtask

    initial begin
        int probe_base;
        resetN = 1'b1;
        hsync  = 1'b1;
        vsync  = 1'b1;
        {red, green, blue} = 12'h000;
        probeH = 10'(PRB_H);
        probeV = 10'(PRB_V);
        exp_err = 0; exp_meas = 0; streak = 0; meas_base = 0; armed = 1'b0;
        p_n = 0; p_v = 0; p_lastlen = 0; p_lasthsw = 0; p_good = 1'b0;
        repeat (2) pix(1'b1, 1'b1, 12'h000);
        do_reset();

        // Standard frames until lock.
        repeat (4) good_frame();
        check("lock_after_good_frames", 32'(locked), 32'd1);

        // One over-long line as the last line of a locked frame.
        send_frame(V_T, V_S, -1, 0, V_T - 1, H_T + 1);
        good_frame();
        check("long_line_errorCount", 32'(errorCount), 32'd1);

        // Relock, then stop hsync entirely.
        repeat (2) good_frame();
        idle_timeout();

        // Frames one line short never lock and never count errors.
        repeat (10) send_frame(V_T - 1, V_S, -1, 0, -1, 0);
        check("short_frames_errorCount", 32'(errorCount), 32'(exp_err));

        // Randomized mix of good and faulty frames.
        probe_base = probe_seen;
        for (int f = 0; f < 14; f++) begin
            int kind;
            kind = $urandom_range(0, 6);
            case (kind)
                3: send_frame(V_T, V_S, -1, 0, $urandom_range(0, V_T - 1),
                              ($urandom_range(0, 1) == 1) ? H_T + $urandom_range(1, 3) : H_T - 2);
                4: send_frame(($urandom_range(0, 1) == 1) ? V_T - 1 : V_T + 1, V_S, -1, 0, -1, 0);
                5: send_frame(V_T, V_S, $urandom_range(0, V_T - 1), H_S + $urandom_range(1, 2), -1, 0);
                6: send_frame(V_T, ($urandom_range(0, 1) == 1) ? 1 : 3, -1, 0, -1, 0);
                default: good_frame();
            endcase
        end
        check("probe_pulses", 32'(probe_seen - probe_base), 32'(14 * EXP_PPF));

        // Lock, then reset mid-line and relock.
        repeat (3) good_frame();
        check("locked_before_reset", 32'(locked), 32'd1);
        for (int p = 0; p < 15; p++) pix(logic'(p >= H_S), 1'b1, 12'h123);
        do_reset();
        repeat (4) good_frame();
        check("relock_after_reset", 32'(locked), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_monitor.md
VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

Interface
REQ-001 The parameter list SHALL be, one per line: name, default, meaning.
- H_TOTAL, 800, expected clocks per line
- H_SYNC, 96, expected hsync low width in clocks
- V_TOTAL, 525, expected lines per frame
- V_SYNC, 2, expected vsync low width in lines
- LOCK_FRAMES, 2, consecutive good frames needed to lock (1..7)
REQ-002 The ports SHALL be, one per line: name, direction, width, meaning.
- clock25MHz, in, 1, pixel clock; only clock
- resetN, in, 1, asynchronous active-low reset
- hsync, in, 1, monitored horizontal sync, active low
- vsync, in, 1, monitored vertical sync, active low
- red/green/blue, in, 4 each, monitored colour
- probeH, in, 10, probe clock index within line
- probeV, in, 10, probe line index within frame
- lineLength, out, 11, last measured clocks per line
- hsyncWidth, out, 8, last measured hsync low width
- frameLines, out, 10, last measured lines per frame
- vsyncWidth, out, 4, last measured vsync width in lines
- locked, out, 1, timing matches parameters
- measValid, out, 1, one-cycle pulse per completed frame
- errorCount, out, 8, frames lost from lock, saturating
- probeRGB, out, 12, sampled {red,green,blue}
- probeValid, out, 1, one-cycle pulse on probe sample

Function
REQ-003 hsync, vsync, red, green and blue SHALL each pass through a 2-flop register chain; all logic SHALL use the delayed copies.
REQ-004 Line start SHALL be a falling edge of delayed hsync (hFall); frame start SHALL be a falling edge of delayed vsync (vFall).
REQ-005 hCnt SHALL increment every clock, saturate at 2047, and load 0 on hFall; on hFall, lineLength SHALL be loaded with the pre-edge hCnt+1, saturated to 2047.
REQ-006 hsync low clocks SHALL be counted, saturating at 255, and latched into hsyncWidth on the hsync rising edge.
REQ-007 lineCnt SHALL increment on each hFall, saturating at 1023; on vFall, frameLines SHALL be loaded with the lineCnt value including a coincident hFall, and lineCnt SHALL load 0.
REQ-008 vsyncWidth SHALL count hFall events while vsync is low, saturate at 15, and latch on the vsync rising edge.
REQ-009 A sticky frameBad flag SHALL be set by any hFall with lineLength != H_TOTAL or any hsync rising edge with hsyncWidth != H_SYNC; it SHALL be evaluated and cleared at vFall.
REQ-010 A frame SHALL be good when frameBad == 0, frameLines == V_TOTAL, and the last vsyncWidth == V_SYNC.
REQ-011 The FSM SHALL have states SEARCH, CHECK and LOCKED.
- SEARCH: on first vFall, go to CHECK with goodCnt=0.
- CHECK: on vFall, a good frame increments goodCnt and reaching LOCK_FRAMES goes to LOCKED; a bad frame clears goodCnt.
- LOCKED: on vFall, a bad frame goes to CHECK, clears goodCnt and increments errorCount, saturating at 255.
REQ-012 If no hFall occurs for 2048 consecutive clocks, the FSM SHALL return to SEARCH from any state and errorCount SHALL increment if the FSM was LOCKED.
REQ-013 locked SHALL be 1 only in LOCKED; measValid SHALL pulse one clock after each vFall evaluated in CHECK or LOCKED.

Reset
REQ-014 When resetN is low, all flops SHALL clear asynchronously, the FSM SHALL enter SEARCH, and every output SHALL be 0.
REQ-015 Reset asserted mid-frame SHALL discard partial measurements; after release, no measValid SHALL occur before the second vFall.

Configuration
REQ-016 With VGA_PIXEL_PROBE_EN defined, probeRGB SHALL be loaded with delayed RGB and probeValid SHALL pulse for one clock when hCnt == probeH and lineCnt == probeV.
REQ-017 Without VGA_PIXEL_PROBE_EN, probeH and probeV SHALL be ignored and probeRGB and probeValid SHALL be held at 0.

Verification
REQ-018 Three standard 640x480 frames (800/96/525/2) -> measValid on frames 1 and 2; locked=1 one clock after the second evaluated vFall; errorCount=0.
REQ-019 Locked, then one line of 801 clocks -> at the next vFall: locked=0, errorCount=1, lineLength=801 after that line.
REQ-020 hsync held high for 3000 clocks while LOCKED -> locked=0 within 2048 clocks of the last hFall; FSM in SEARCH; errorCount incremented.
REQ-021 Frame of 524 lines -> frameLines=524, no lock; 10 such frames -> errorCount stays 0.
REQ-022 With VGA_PIXEL_PROBE_EN defined, probeH=200, probeV=40, red/green/blue=F/0/A at that point -> probeRGB=12'hF0A with a single probeValid pulse per frame; without the macro -> probeRGB=0.
REQ-023 resetN pulsed low mid-line while LOCKED -> all outputs 0 immediately; relock after two good frames.
